line_buffer: RTL and testbench
==============================

Name: line_buffer

Overview:
- Column-addressed line buffer for a sliding-window engine on a 1-bit (binary) image stream.
- Holds the previous WindowSize-1 image rows, each ImageWidth pixels.
- Each write at column Addr pushes the new pixel into the bottom of that column and ages the older pixels up one row.
- Registered output LineData gives the stored column at Addr, feeding the window register array.

Parameters:
- AddrWidth, 3, width of Addr; must satisfy 2^AddrWidth >= ImageWidth.
- ImageWidth, 7, pixels per image row (number of columns stored).
- WindowSize, 3, window edge length n; the buffer stores n-1 rows; must be >= 2.

Ports:
- Clock  input  1  system clock, rising-edge active.
- Reset  input  1  asynchronous, active-high; clears storage and outputs.
- WriteEnable  input  1  push Data into column Addr this cycle.
- Addr  input  AddrWidth  column index, 0..ImageWidth-1.
- Data  input  1  incoming pixel.
- LineData  output  WindowSize-1  stored column; bit 0 = newest row, bit WindowSize-2 = oldest row.

Behaviour:
- Storage: array row[r][c], r = 0..WindowSize-2, c = 0..ImageWidth-1, 1 bit each.
- Reset asserted (asynchronous): all row bits = 0; LineData = 0. Output stays 0 while Reset is high.
- LineData timing:
  - Every rising edge with Reset low and Addr < ImageWidth: LineData <= {row[WindowSize-2][Addr], ..., row[0][Addr]}.
  - The register is updated regardless of WriteEnable.
  - Latency is 1 clock.
  - Read-before-write: on a write edge, LineData captures the column contents from before that write.
- Write (WriteEnable=1, Addr < ImageWidth), at the same edge:
  - row[0][Addr] <= Data.
  - row[r][Addr] <= row[r-1][Addr] for r = 1..WindowSize-2.
  - Oldest pixel row[WindowSize-2][Addr] is discarded.
  - All other columns are unchanged.
- WriteEnable=0: storage holds.
- Out of range (Addr >= ImageWidth): write ignored, storage unchanged; LineData <= 0 at that edge.
- Consecutive writes to the same column on back-to-back cycles each shift once. There is no write coalescing.
- WindowSize=2: a write simply replaces row[0][Addr]; LineData is 1 bit.
- No handshake, no stall: one write per cycle maximum, unconditionally accepted.
- Addr, Data and WriteEnable are sampled only at the rising edge; there is no combinational path from inputs to LineData.
- Reset deasserted mid-stream: operation resumes from the all-zero state on the next edge.

Optional Feature:
- Macro: LINEBUF_ADDR_ERR_EN.
- Defined:
  - Adds output AddrError (1 bit).
  - AddrError is registered: at each rising edge, AddrError <= (Addr >= ImageWidth), regardless of WriteEnable.
  - Reset value is 0.
- Not defined: port AddrError is absent. Out-of-range handling is otherwise identical (write ignored, LineData <= 0).

Test Plan:
- Reset: assert Reset asynchronously mid-cycle with arbitrary stored data -> LineData=0 immediately. Then read every column with WriteEnable=0 -> LineData=0 for all.
- Single write, then read (defaults n=3, width 7):
  - Write Data=1 at Addr=0; next edge reads Addr=0 with WriteEnable=0 -> LineData=2'b01.
  - Write Data=1 at Addr=5 -> column 5 reads 2'b01; column 0 still 2'b01.
- Shift plus read-before-write: after the above, write Data=0 at Addr=0.
  - LineData at that edge = 2'b01 (old column).
  - Subsequent read of Addr=0 -> 2'b10.
  - A further write of Data=1 at Addr=0 -> LineData=2'b10, next read 2'b01 (oldest 1 dropped).
- Column isolation: fill columns 0..6 with alternating Data 1,0 over two passes. Each column reads {first pass, second pass} value; no cross-column disturbance.
- Out of range: WriteEnable=1, Addr=7, Data=1 -> LineData=0 at that edge, all columns unchanged. With LINEBUF_ADDR_ERR_EN defined, AddrError=1 for that cycle, 0 for the next in-range cycle.
- Parameter sweep: WindowSize=2 and WindowSize=5 (ImageWidth=7) -> shift depth matches n-1. For n=5, four writes 1,0,0,0 to one column read back 4'b1000.

Source files
------------

// File: rtl/line_buffer.sv
// line_buffer: column-addressed line buffer for a binary-image sliding-window engine.
//
// Stores the previous WindowSize-1 rows of ImageWidth 1-bit pixels. A write at
// column Addr pushes Data into the newest row of that column and ages the older
// pixels of the same column by one row, dropping the oldest. LineData is a
// registered read of the column at Addr, sampled before any write on that edge.
//
// Ports:
//   Clock        in   rising-edge clock
//   Reset        in   asynchronous active-high reset, clears storage and outputs
//   WriteEnable  in   push Data into column Addr this cycle
//   Addr         in   column index, 0..ImageWidth-1 (larger values are ignored)
//   Data         in   incoming pixel
//   LineData     out  stored column; bit 0 = newest row, bit WindowSize-2 = oldest
//   AddrError    out  registered (Addr >= ImageWidth) flag, only when the macro
//                     LINEBUF_ADDR_ERR_EN is defined
//
// Parameters:
//   AddrWidth    width of Addr, 2**AddrWidth >= ImageWidth
//   ImageWidth   pixels per row
//   WindowSize   window edge n (>= 2); n-1 rows are stored

module line_buffer #(
  parameter int unsigned AddrWidth  = 3,
  parameter int unsigned ImageWidth = 7,
  parameter int unsigned WindowSize = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  WriteEnable,
  input  logic [AddrWidth-1:0]  Addr,
  input  logic                  Data,
`ifdef LINEBUF_ADDR_ERR_EN
  output logic [WindowSize-2:0] LineData,
  output logic                  AddrError
`else
  output logic [WindowSize-2:0] LineData
`endif
);

  localparam int unsigned Depth = WindowSize - 1;

  // One shift register per column; bit 0 holds the newest row.
  logic [Depth-1:0] col_q [ImageWidth];
  logic [Depth-1:0] rd_col;
  logic             in_range;

  // Extra bit keeps the compare exact when ImageWidth == 2**AddrWidth.
  assign in_range = ({1'b0, Addr} < (AddrWidth + 1)'(ImageWidth));

  // Age a column by one row and insert the new pixel at the newest position.
  // Shifting (rather than concatenating) also covers the single-row case.
  function automatic logic [Depth-1:0] push_pixel(input logic [Depth-1:0] col,
                                                  input logic             pix);
    logic [Depth-1:0] res;
    res    = col << 1;
    res[0] = pix;
    return res;
  endfunction

  // Column read mux, decoded by compare so an out-of-range Addr never indexes
  // past the array.
  always_comb begin
    rd_col = '0;
    for (int c = 0; c < ImageWidth; c++) begin
      if (Addr == AddrWidth'(c)) begin
        rd_col = col_q[c];
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int c = 0; c < ImageWidth; c++) begin
        col_q[c] <= '0;
      end
      LineData <= '0;
    end else begin
      // Read uses the pre-write column value (read-before-write).
      LineData <= in_range ? rd_col : '0;
      for (int c = 0; c < ImageWidth; c++) begin
        if (WriteEnable && in_range && (Addr == AddrWidth'(c))) begin
          col_q[c] <= push_pixel(col_q[c], Data);
        end
      end
    end
  end

`ifdef LINEBUF_ADDR_ERR_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      AddrError <= 1'b0;
    end else begin
      AddrError <= ~in_range;
    end
  end
`endif

endmodule

// File: tb/tb_line_buffer.sv
// tb_line_buffer: scoreboard bench for line_buffer.
//
// Three instances (WindowSize 3, 2 and 5, ImageWidth 7) share one stimulus
// stream. Each stimulus cycle pushes its hand-computed expected response into a
// queue; a monitor pops and compares one entry after every rising edge. The
// expected value is written as the 4-row column of the n=5 instance; because
// all instances see the same writes, the n=3 and n=2 columns are its low bits.

module tb_line_buffer;

  logic       Clock;
  logic       Reset;
  logic       WriteEnable;
  logic [2:0] Addr;
  logic       Data;
  logic [1:0] ld3;
  logic [0:0] ld2;
  logic [3:0] ld5;
  logic       err3;
  logic       err2;
  logic       err5;

  int total;
  int bad;

  typedef struct packed {
    logic [3:0] col;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

`ifdef LINEBUF_ADDR_ERR_EN
  line_buffer #(.AddrWidth(3), .ImageWidth(7), .WindowSize(3)) dut3 (
    .Clock(Clock), .Reset(Reset), .WriteEnable(WriteEnable), .Addr(Addr),
    .Data(Data), .LineData(ld3), .AddrError(err3));
  line_buffer #(.AddrWidth(3), .ImageWidth(7), .WindowSize(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .WriteEnable(WriteEnable), .Addr(Addr),
    .Data(Data), .LineData(ld2), .AddrError(err2));
  line_buffer #(.AddrWidth(3), .ImageWidth(7), .WindowSize(5)) dut5 (
    .Clock(Clock), .Reset(Reset), .WriteEnable(WriteEnable), .Addr(Addr),
    .Data(Data), .LineData(ld5), .AddrError(err5));
`else
  line_buffer #(.AddrWidth(3), .ImageWidth(7), .WindowSize(3)) dut3 (
    .Clock(Clock), .Reset(Reset), .WriteEnable(WriteEnable), .Addr(Addr),
    .Data(Data), .LineData(ld3));
  line_buffer #(.AddrWidth(3), .ImageWidth(7), .WindowSize(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .WriteEnable(WriteEnable), .Addr(Addr),
    .Data(Data), .LineData(ld2));
  line_buffer #(.AddrWidth(3), .ImageWidth(7), .WindowSize(5)) dut5 (
    .Clock(Clock), .Reset(Reset), .WriteEnable(WriteEnable), .Addr(Addr),
    .Data(Data), .LineData(ld5));
  assign err3 = 1'b0;
  assign err2 = 1'b0;
  assign err5 = 1'b0;
`endif

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // One stimulus cycle: drive on the falling edge, expect the response after
  // the following rising edge.
  task automatic step(input logic we, input logic [2:0] a, input logic d,
                      input logic [3:0] col, input logic err);
    exp_t e;
    @(negedge Clock);
    WriteEnable = we;
    Addr        = a;
    Data        = d;
    e.col       = col;
    e.err       = err;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    total++;
    if (ld3 !== 2'b00 || ld2 !== 1'b0 || ld5 !== 4'b0000) begin
      bad++;
      $display("FAIL %s: n3=%b n2=%b n5=%b required all zero", name, ld3, ld2, ld5);
    end
  endtask

  // Monitor: compares every DUT output against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (ld5 !== e.col || ld3 !== e.col[1:0] || ld2 !== e.col[0:0]) begin
          bad++;
          $display("FAIL linedata t=%0t: n5=%b n3=%b n2=%b required n5=%b n3=%b n2=%b",
                   $time, ld5, ld3, ld2, e.col, e.col[1:0], e.col[0]);
        end
`ifdef LINEBUF_ADDR_ERR_EN
        total++;
        if (err3 !== e.err || err2 !== e.err || err5 !== e.err) begin
          bad++;
          $display("FAIL addrerror t=%0t: got %b%b%b required %b", $time, err3, err2, err5,
                   e.err);
        end
`endif
      end
    end
  end

  initial begin
    total       = 0;
    bad         = 0;
    Reset       = 1'b1;
    WriteEnable = 1'b0;
    Addr        = 3'd0;
    Data        = 1'b0;
    #2;
    check_zero("reset_initial");
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;

    // Single writes and shifting with read-before-write.
    step(1'b1, 3'd0, 1'b1, 4'b0000, 1'b0);
    step(1'b0, 3'd0, 1'b0, 4'b0001, 1'b0);
    step(1'b1, 3'd5, 1'b1, 4'b0000, 1'b0);
    step(1'b0, 3'd5, 1'b1, 4'b0001, 1'b0);  // Data ignored when not writing
    step(1'b0, 3'd0, 1'b0, 4'b0001, 1'b0);
    step(1'b1, 3'd0, 1'b0, 4'b0001, 1'b0);
    step(1'b0, 3'd0, 1'b0, 4'b0010, 1'b0);
    step(1'b1, 3'd0, 1'b1, 4'b0010, 1'b0);
    step(1'b0, 3'd0, 1'b0, 4'b0101, 1'b0);

    // Asynchronous reset mid-cycle with data stored.
    @(posedge Clock);
    #3;
    Reset = 1'b1;
    #1;
    check_zero("reset_async");
    @(negedge Clock);
    Reset = 1'b0;

    for (int c = 0; c < 7; c++) begin
      step(1'b0, 3'(c), 1'b1, 4'b0000, 1'b0);
    end
    step(1'b0, 3'd7, 1'b0, 4'b0000, 1'b1);
    step(1'b0, 3'd0, 1'b0, 4'b0000, 1'b0);

    // Column isolation: pass 1 alternates 1,0; pass 2 alternates 0,1.
    for (int c = 0; c < 7; c++) begin
      step(1'b1, 3'(c), ~c[0], 4'b0000, 1'b0);
    end
    for (int c = 0; c < 7; c++) begin
      step(1'b1, 3'(c), c[0], c[0] ? 4'b0000 : 4'b0001, 1'b0);
    end
    for (int c = 0; c < 7; c++) begin
      step(1'b0, 3'(c), 1'b0, c[0] ? 4'b0001 : 4'b0010, 1'b0);
    end

    // Out-of-range write is dropped and reads as zero.
    step(1'b1, 3'd7, 1'b1, 4'b0000, 1'b1);
    for (int c = 0; c < 7; c++) begin
      step(1'b0, 3'(c), 1'b0, c[0] ? 4'b0001 : 4'b0010, 1'b0);
    end

    // Back-to-back writes to one column each shift once.
    step(1'b1, 3'd3, 1'b1, 4'b0001, 1'b0);
    step(1'b1, 3'd3, 1'b1, 4'b0011, 1'b0);
    step(1'b0, 3'd3, 1'b0, 4'b0111, 1'b0);

    // Depth check: four writes 1,0,0,0 flush column 6 to 4'b1000 for n=5.
    step(1'b1, 3'd6, 1'b1, 4'b0010, 1'b0);
    step(1'b1, 3'd6, 1'b0, 4'b0101, 1'b0);
    step(1'b1, 3'd6, 1'b0, 4'b1010, 1'b0);
    step(1'b1, 3'd6, 1'b0, 4'b0100, 1'b0);
    step(1'b0, 3'd6, 1'b0, 4'b1000, 1'b0);
    step(1'b0, 3'd5, 1'b0, 4'b0001, 1'b0);

    @(negedge Clock);
    WriteEnable = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
